// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decoder definitions: marker codes, unstuffer states, buffer defaults.
// Optional statistics outputs are enabled by the JPEG_BITSTREAM_STATS_EN macro.
package jpeg_dec_pkg;

  localparam int BUF_WIDTH_DEF  = 32;
  localparam int PEEK_WIDTH_DEF = 16;

  localparam logic [7:0] MRK_PREFIX = 8'hFF;
  localparam logic [7:0] MRK_STUFF  = 8'h00;
  localparam logic [7:0] MRK_SOI    = 8'hD8;
  localparam logic [7:0] MRK_EOI    = 8'hD9;
  localparam logic [7:0] MRK_RST0   = 8'hD0;
  localparam logic [7:0] MRK_RST1   = 8'hD1;
  localparam logic [7:0] MRK_RST2   = 8'hD2;
  localparam logic [7:0] MRK_RST3   = 8'hD3;
  localparam logic [7:0] MRK_RST4   = 8'hD4;
  localparam logic [7:0] MRK_RST5   = 8'hD5;
  localparam logic [7:0] MRK_RST6   = 8'hD6;
  localparam logic [7:0] MRK_RST7   = 8'hD7;

  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_FF     = 2'd1,
    S_MARKER = 2'd2
  } unstuff_state_t;

  // True for RST0..RST7, which share the top five bits 11010.
  function automatic logic is_rst_marker(input logic [7:0] code);
    return (code[7:3] == MRK_RST0[7:3]);
  endfunction

endpackage

// File: rtl/jpeg_byte_unstuffer.sv
// Byte-level front end: strips 0xFF00 stuffing, drops 0xFF fill, captures markers.
// With JPEG_BITSTREAM_STATS_EN defined it also counts unstuffed pairs and fill bytes.
module jpeg_byte_unstuffer
  import jpeg_dec_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_flush,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_data,
  input  logic       i_space_ok,
  input  logic       i_marker_ack,
  output logic       o_byte_ready,
  output logic       o_append_valid,
  output logic [7:0] o_append_byte,
  output logic       o_marker_valid,
  output logic [7:0] o_marker_code
`ifdef JPEG_BITSTREAM_STATS_EN
  ,
  output logic [15:0] o_stuffed_cnt,
  output logic [15:0] o_fill_cnt
`endif
);

  unstuff_state_t r_state;
  unstuff_state_t w_state_next;
  logic           w_accept;
  logic           w_stuff_evt;
  logic           w_fill_evt;
  logic           w_marker_evt;
  logic           r_marker_valid;
  logic [7:0]     r_marker_code;

  assign w_accept = i_byte_valid && o_byte_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_state <= S_DATA;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_DATA: begin
        if (w_accept && i_byte_data == MRK_PREFIX) w_state_next = S_FF;
      end
      S_FF: begin
        if (w_accept) begin
          if (i_byte_data == MRK_STUFF)       w_state_next = S_DATA;
          else if (i_byte_data != MRK_PREFIX) w_state_next = S_MARKER;
        end
      end
      S_MARKER: begin
        if (i_marker_ack) w_state_next = S_DATA;
      end
      default: w_state_next = S_DATA;
    endcase
  end

  always_comb begin
    o_byte_ready   = !i_reset && !i_flush && (r_state != S_MARKER) && i_space_ok;
    o_append_valid = 1'b0;
    o_append_byte  = i_byte_data;
    w_stuff_evt    = 1'b0;
    w_fill_evt     = 1'b0;
    w_marker_evt   = 1'b0;
    case (r_state)
      S_DATA: begin
        o_append_valid = w_accept && (i_byte_data != MRK_PREFIX);
      end
      S_FF: begin
        if (w_accept) begin
          if (i_byte_data == MRK_STUFF) begin
            o_append_valid = 1'b1;
            o_append_byte  = MRK_PREFIX;
            w_stuff_evt    = 1'b1;
          end else if (i_byte_data == MRK_PREFIX) begin
            w_fill_evt = 1'b1;
          end else begin
            w_marker_evt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // The marker code survives flush so the decoder can still inspect it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_marker_valid <= 1'b0;
      r_marker_code  <= 8'h00;
    end else if (i_flush) begin
      r_marker_valid <= 1'b0;
    end else if (w_marker_evt) begin
      r_marker_valid <= 1'b1;
      r_marker_code  <= i_byte_data;
    end else if (r_state == S_MARKER && i_marker_ack) begin
      r_marker_valid <= 1'b0;
    end
  end

  assign o_marker_valid = r_marker_valid;
  assign o_marker_code  = r_marker_code;

`ifdef JPEG_BITSTREAM_STATS_EN
  logic [15:0] r_stuffed_cnt;
  logic [15:0] r_fill_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_stuffed_cnt <= 16'h0000;
      r_fill_cnt    <= 16'h0000;
    end else begin
      if (w_stuff_evt && r_stuffed_cnt != 16'hFFFF) r_stuffed_cnt <= r_stuffed_cnt + 16'd1;
      if (w_fill_evt && r_fill_cnt != 16'hFFFF)     r_fill_cnt    <= r_fill_cnt + 16'd1;
    end
  end

  assign o_stuffed_cnt = r_stuffed_cnt;
  assign o_fill_cnt    = r_fill_cnt;
`endif

endmodule

// File: rtl/jpeg_bitstream_unpacker.sv
// Left-aligned bit buffer fed by the byte unstuffer; peek/consume port for Huffman decode.
// Defining JPEG_BITSTREAM_STATS_EN exposes stuffed_cnt and fill_cnt outputs.
module jpeg_bitstream_unpacker
  import jpeg_dec_pkg::*;
#(
  parameter int BUF_WIDTH  = BUF_WIDTH_DEF,
  parameter int PEEK_WIDTH = PEEK_WIDTH_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic [PEEK_WIDTH-1:0] o_peek_bits,
  output logic [5:0]            o_bits_avail,
  input  logic                  i_consume_valid,
  input  logic [4:0]            i_consume_len,
  input  logic                  i_flush,
  output logic                  o_marker_valid,
  output logic [7:0]            o_marker_code,
  input  logic                  i_marker_ack,
  output logic                  o_err_underflow
`ifdef JPEG_BITSTREAM_STATS_EN
  ,
  output logic [15:0]           o_stuffed_cnt,
  output logic [15:0]           o_fill_cnt
`endif
);

  logic [BUF_WIDTH-1:0] r_buf;
  logic [5:0]           r_bits_avail;
  logic                 r_err_underflow;

  logic                 w_space_ok;
  logic                 w_append_valid;
  logic [7:0]           w_append_byte;
  logic                 w_consume_ok;
  logic [BUF_WIDTH-1:0] w_buf_c;
  logic [5:0]           w_avail_c;
  logic [BUF_WIDTH-1:0] w_append_word;
  logic [BUF_WIDTH-1:0] w_buf_next;
  logic [5:0]           w_avail_next;

  assign w_space_ok = (r_bits_avail <= 6'(BUF_WIDTH - 8));

  jpeg_byte_unstuffer u_unstuffer (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_byte_valid   (i_byte_valid),
    .i_byte_data    (i_byte_data),
    .i_space_ok     (w_space_ok),
    .i_marker_ack   (i_marker_ack),
    .o_byte_ready   (o_byte_ready),
    .o_append_valid (w_append_valid),
    .o_append_byte  (w_append_byte),
    .o_marker_valid (o_marker_valid),
    .o_marker_code  (o_marker_code)
`ifdef JPEG_BITSTREAM_STATS_EN
    ,
    .o_stuffed_cnt  (o_stuffed_cnt),
    .o_fill_cnt     (o_fill_cnt)
`endif
  );

  // Consume first, then append right below whatever bits remain.
  assign w_consume_ok  = i_consume_valid && (i_consume_len != 5'd0) &&
                         ({1'b0, i_consume_len} <= r_bits_avail);
  assign w_buf_c       = w_consume_ok ? (r_buf << i_consume_len) : r_buf;
  assign w_avail_c     = w_consume_ok ? (r_bits_avail - {1'b0, i_consume_len}) : r_bits_avail;
  assign w_append_word = {w_append_byte, {(BUF_WIDTH - 8){1'b0}}};
  assign w_buf_next    = w_append_valid ? (w_buf_c | (w_append_word >> w_avail_c)) : w_buf_c;
  assign w_avail_next  = w_append_valid ? (w_avail_c + 6'd8) : w_avail_c;

  // Bits below the valid region are kept zero, so the peek window needs no masking.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_buf           <= '0;
      r_bits_avail    <= 6'd0;
      r_err_underflow <= 1'b0;
    end else begin
      r_buf        <= w_buf_next;
      r_bits_avail <= w_avail_next;
      if (i_consume_valid && !w_consume_ok) r_err_underflow <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < PEEK_WIDTH; gi++) begin : g_peek
      assign o_peek_bits[gi] = r_buf[BUF_WIDTH - PEEK_WIDTH + gi];
    end
  endgenerate

  assign o_bits_avail    = r_bits_avail;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// Directed bench for jpeg_bitstream_unpacker with a bit-queue reference model.
module tb_jpeg_bitstream_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bv = 1'b0;
  logic [7:0]  bd = 8'h00;
  logic        cv = 1'b0;
  logic [4:0]  cl = 5'd0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;

  logic        byte_ready;
  logic [15:0] peek_bits;
  logic [5:0]  bits_avail;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        err_underflow;
`ifdef JPEG_BITSTREAM_STATS_EN
  logic [15:0] stuffed_cnt;
  logic [15:0] fill_cnt;
`endif

  int checks = 0;
  int failures = 0;
  bit run = 1'b1;

  always #5 clk = ~clk;

  jpeg_bitstream_unpacker dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_byte_valid    (bv),
    .i_byte_data     (bd),
    .o_byte_ready    (byte_ready),
    .o_peek_bits     (peek_bits),
    .o_bits_avail    (bits_avail),
    .i_consume_valid (cv),
    .i_consume_len   (cl),
    .i_flush         (flush),
    .o_marker_valid  (marker_valid),
    .o_marker_code   (marker_code),
    .i_marker_ack    (ack),
    .o_err_underflow (err_underflow)
`ifdef JPEG_BITSTREAM_STATS_EN
    ,
    .o_stuffed_cnt   (stuffed_cnt),
    .o_fill_cnt      (fill_cnt)
`endif
  );

  // Reference model: the buffer is simply a queue of bits, oldest first.
  bit         mq[$];
  bit         m_pend_ff = 1'b0;
  bit         m_mvalid = 1'b0;
  logic [7:0] m_code = 8'h00;
  bit         m_err = 1'b0;
  int         m_stuffed = 0;
  int         m_fill = 0;

  function automatic logic model_ready();
    return !rst && !flush && !m_mvalid && (mq.size() <= 24);
  endfunction

  function automatic logic [15:0] model_peek();
    logic [15:0] p = 16'h0000;
    for (int i = 0; i < 16; i++) if (i < mq.size()) p[15-i] = mq[i];
    return p;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
  endtask

  task automatic model_step();
    bit acc;
    if (rst) begin
      mq.delete(); m_pend_ff = 0; m_mvalid = 0; m_code = 8'h00; m_err = 0;
      m_stuffed = 0; m_fill = 0;
    end else if (flush) begin
      mq.delete(); m_pend_ff = 0; m_mvalid = 0; m_err = 0; m_stuffed = 0; m_fill = 0;
    end else begin
      acc = bv && model_ready();
      if (cv) begin
        if (cl >= 1 && int'(cl) <= mq.size()) begin
          for (int i = 0; i < int'(cl); i++) void'(mq.pop_front());
        end else begin
          m_err = 1;
        end
      end
      if (m_mvalid && ack) m_mvalid = 0;
      if (acc) begin
        if (m_pend_ff) begin
          if (bd == 8'h00) begin
            push_byte(8'hFF); m_pend_ff = 0;
            if (m_stuffed < 65535) m_stuffed++;
          end else if (bd == 8'hFF) begin
            if (m_fill < 65535) m_fill++;
          end else begin
            m_mvalid = 1; m_code = bd; m_pend_ff = 0;
          end
        end else if (bd == 8'hFF) begin
          m_pend_ff = 1;
        end else begin
          push_byte(bd);
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model_peek", peek_bits, model_peek());
      chk("model_avail", bits_avail, mq.size());
      chk("model_ready", byte_ready, model_ready());
      chk("model_mvalid", marker_valid, m_mvalid);
      chk("model_mcode", marker_code, m_code);
      chk("model_err", err_underflow, m_err);
`ifdef JPEG_BITSTREAM_STATS_EN
      chk("model_stuffed", stuffed_cnt, m_stuffed);
      chk("model_fill", fill_cnt, m_fill);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bv = 1'b1; bd = b; tick(); bv = 1'b0;
  endtask

  task automatic consume(input logic [4:0] n);
    cv = 1'b1; cl = n; tick(); cv = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready", byte_ready, 0);
    chk("rst_avail", bits_avail, 0);
    chk("rst_peek", peek_bits, 16'h0000);
    chk("rst_mvalid", marker_valid, 0);
    chk("rst_err", err_underflow, 0);
    rst = 1'b0; #1;

    send(8'hA5); send(8'h3C); tick();
    chk("two_bytes_avail", bits_avail, 16);
    chk("two_bytes_peek", peek_bits, 16'hA53C);

    consume(5'd3);
    chk("consume3_peek", peek_bits, 16'h29E0);
    chk("consume3_avail", bits_avail, 13);
    cv = 1'b1; cl = 5'd13; bv = 1'b1; bd = 8'h7E; tick(); cv = 1'b0; bv = 1'b0;
    chk("cons_app_avail", bits_avail, 8);
    chk("cons_app_peek", peek_bits, 16'h7E00);

    do_flush();
    send(8'hFF); send(8'h00); send(8'h12);
    chk("stuff_avail", bits_avail, 16);
    chk("stuff_peek", peek_bits, 16'hFF12);
`ifdef JPEG_BITSTREAM_STATS_EN
    chk("stuff_cnt", stuffed_cnt, 1);
`endif

    consume(5'd8);
    send(8'hFF); send(8'hFF);
    bv = 1'b1; bd = 8'hD9; tick();
    bd = 8'h55; tick(); tick();
    chk("marker_valid", marker_valid, 1);
    chk("marker_code", marker_code, 8'hD9);
    chk("marker_ready", byte_ready, 0);
    chk("marker_avail", bits_avail, 8);
    bv = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    chk("marker_acked", marker_valid, 0);
`ifdef JPEG_BITSTREAM_STATS_EN
    chk("fill_cnt", fill_cnt, 1);
`endif
    send(8'h55);
    chk("post_marker_peek", peek_bits, 16'h1255);

    do_flush();
    send(8'hB8); consume(5'd3);
    consume(5'd6); tick(); tick();
    chk("uflow_err", err_underflow, 1);
    chk("uflow_avail", bits_avail, 5);
    chk("uflow_peek", peek_bits, 16'hC000);
    do_flush();
    chk("flush_avail", bits_avail, 0);
    chk("flush_err", err_underflow, 0);
    consume(5'd0);
    chk("zero_len_err", err_underflow, 1);
    do_flush();

    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("full_avail", bits_avail, 32);
    bv = 1'b1; bd = 8'h55; #1;
    chk("full_ready", byte_ready, 0);
    tick();
    cv = 1'b1; cl = 5'd8; #1;
    chk("full_cons_ready", byte_ready, 0);
    tick(); cv = 1'b0; #1;
    chk("after_cons_avail", bits_avail, 24);
    chk("after_cons_ready", byte_ready, 1);
    tick(); bv = 1'b0;
    chk("refill_avail", bits_avail, 32);
    chk("refill_peek", peek_bits, 16'h2233);

    bv = 1'b1; bd = 8'hAA; flush = 1'b1; #1;
    chk("flush_ready", byte_ready, 0);
    tick(); flush = 1'b0; bv = 1'b0;
    chk("flush_byte_dropped", bits_avail, 0);

    send(8'hFF); send(8'hD0);
    chk("rst0_marker", marker_valid, 1);
    do_flush();
    chk("flush_marker", marker_valid, 0);

    send(8'hA0); send(8'hFF);
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h00);
    chk("rst_ff_avail", bits_avail, 8);
    chk("rst_ff_peek", peek_bits, 16'h0000);
    tick();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
